// File: rtl/texel_serializer_if.sv
// Handshake bundle between a triangle source, the serializer and the
// downstream word sink. The master side is the source/sink environment,
// the slave side is the serializer itself.
//
// texel_vertices_in layout: {p, q, r}, each vertex packed as {x, y, z}
// with x in the most significant 16 bits.
// texel_color_in layout: {r, g, b} with r in the most significant byte.
interface texel_serializer_if;
  logic [143:0] texel_vertices_in;
  logic [23:0]  texel_color_in;
  logic         texel_valid;
  logic         texel_last;
  logic         texel_read;
  logic [31:0]  word_out;
  logic         word_valid;
  logic         word_ack;

  modport master (
    output texel_vertices_in,
    output texel_color_in,
    output texel_valid,
    output texel_last,
    output word_ack,
    input  texel_read,
    input  word_out,
    input  word_valid
  );

  modport slave (
    input  texel_vertices_in,
    input  texel_color_in,
    input  texel_valid,
    input  texel_last,
    input  word_ack,
    output texel_read,
    output word_out,
    output word_valid
  );
endinterface

// File: rtl/texel_serializer.sv
// Serializes one captured triangle (three 16-bit 3D vertices plus 24-bit
// colour) into a header word, six payload words and an optional trailer,
// in the same packing the receive-side assembler expects.
module texel_serializer #(
  parameter logic [31:0] FRAME_START = 32'd0,
  parameter logic [31:0] FRAME_END   = 32'd1,
  parameter bit          EMIT_END    = 1'b1,
  parameter int          CNT_W       = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  texel_serializer_if.slave  bus,
  output logic               busy,
  output logic [CNT_W-1:0]   triangle_count
);

  typedef enum logic [3:0] {
    IDLE, HDR, W1, W2, W3, W4, W5, W6, END
  } state_t;

  state_t       state;
  state_t       next_state;
  logic [143:0] cap_vert;
  logic [23:0]  cap_col;
  logic         cap_last;
  logic         take;

  // Field views of the captured triangle
  logic [15:0] px, py, pz, qx, qy, qz, rx, ry, rz;
  logic [7:0]  cr, cg, cb;

  assign {px, py, pz, qx, qy, qz, rx, ry, rz} = cap_vert;
  assign {cr, cg, cb} = cap_col;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the triangle only on the accept edge so later input changes are ignored
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cap_vert <= '0;
      cap_col  <= '0;
      cap_last <= 1'b0;
    end else if (state == IDLE && bus.texel_valid) begin
      cap_vert <= bus.texel_vertices_in;
      cap_col  <= bus.texel_color_in;
      cap_last <= bus.texel_last & EMIT_END;
    end
  end

  // Count a triangle as sent once its last payload word is taken; wraps silently
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      triangle_count <= '0;
    end else if (state == W6 && bus.word_ack) begin
      triangle_count <= triangle_count + CNT_W'(1);
    end
  end

  // Next-state and output decode; words advance only when the sink acks
  always_comb begin
    next_state     = state;
    bus.texel_read = 1'b0;
    bus.word_valid = 1'b1;
    bus.word_out   = '0;
    busy           = 1'b1;
    take           = bus.word_ack;
    unique case (state)
      IDLE: begin
        bus.word_valid = 1'b0;
        busy           = 1'b0;
        take           = 1'b0;
        bus.texel_read = bus.texel_valid;
        if (bus.texel_valid) next_state = HDR;
      end
      HDR: begin
        bus.word_out = FRAME_START;
        if (take) next_state = W1;
      end
      W1: begin
        bus.word_out = {py, px};
        if (take) next_state = W2;
      end
      W2: begin
        bus.word_out = {qx, pz};
        if (take) next_state = W3;
      end
      W3: begin
        bus.word_out = {qz, qy};
        if (take) next_state = W4;
      end
      W4: begin
        bus.word_out = {ry, rx};
        if (take) next_state = W5;
      end
      W5: begin
        bus.word_out = {cg, cr, rz};
        if (take) next_state = W6;
      end
      W6: begin
        bus.word_out = {24'h0, cb};
        if (take) next_state = cap_last ? END : IDLE;
      end
      END: begin
        bus.word_out = FRAME_END;
        if (take) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_texel_serializer.sv
// Bench for texel_serializer. Instance A uses the default parameters and
// emits trailers; instance B has trailers disabled and a 2-bit counter.
// A select bit routes the shared stimulus to one instance at a time.
module tb_texel_serializer;

  logic clk = 1'b0;
  logic n_rst;
  logic sel;

  logic [15:0] px, py, pz, qx, qy, qz, rx, ry, rz;
  logic [7:0]  cr, cg, cb;
  logic        src_valid, src_last, src_ack;

  logic        busy_a, busy_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  logic        obs_read, obs_valid, obs_busy;
  logic [31:0] obs_word;

  int assert_count = 0;
  int fail_count   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  int cyc, reads, first_rd, second_rd, n;
  bit changed;

  texel_serializer_if ifa ();
  texel_serializer_if ifb ();

  texel_serializer #(.EMIT_END(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .n_rst(n_rst), .bus(ifa.slave),
    .busy(busy_a), .triangle_count(cnt_a)
  );

  texel_serializer #(.EMIT_END(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .n_rst(n_rst), .bus(ifb.slave),
    .busy(busy_b), .triangle_count(cnt_b)
  );

  always #5 clk = ~clk;

  assign ifa.texel_vertices_in = {px, py, pz, qx, qy, qz, rx, ry, rz};
  assign ifb.texel_vertices_in = {px, py, pz, qx, qy, qz, rx, ry, rz};
  assign ifa.texel_color_in    = {cr, cg, cb};
  assign ifb.texel_color_in    = {cr, cg, cb};
  assign ifa.texel_valid       = src_valid & ~sel;
  assign ifb.texel_valid       = src_valid & sel;
  assign ifa.texel_last        = src_last;
  assign ifb.texel_last        = src_last;
  assign ifa.word_ack          = src_ack & ~sel;
  assign ifb.word_ack          = src_ack & sel;

  assign obs_read  = sel ? ifb.texel_read : ifa.texel_read;
  assign obs_valid = sel ? ifb.word_valid : ifa.word_valid;
  assign obs_word  = sel ? ifb.word_out   : ifa.word_out;
  assign obs_busy  = sel ? busy_b         : busy_a;

  // Scoreboard: expected packet queued at accept, words compared as they are taken
  always @(negedge clk) begin
    if (n_rst && obs_valid && src_ack) begin
      assert_count++;
      assert (exp_q.size() != 0) else begin
        fail_count++;
        $error("[TB] FAIL stream_extra: got word %h, expected no word", obs_word);
      end
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        assert_count++;
        assert (obs_word === exp_w) else begin
          fail_count++;
          $error("[TB] FAIL stream_word: got %h, expected %h", obs_word, exp_w);
        end
      end
    end
    if (n_rst && obs_read) begin
      exp_q.push_back(32'h0000_0000);
      exp_q.push_back({py, px});
      exp_q.push_back({qx, pz});
      exp_q.push_back({qz, qy});
      exp_q.push_back({ry, rx});
      exp_q.push_back({cg, cr, rz});
      exp_q.push_back({24'h0, cb});
      if (src_last && !sel) exp_q.push_back(32'h0000_0001);
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assert_count++;
    assert (obs === expv) else begin
      fail_count++;
      $error("[TB] FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic load_plan_tri();
    px = 16'h0001; py = 16'h0002; pz = 16'h0003;
    qx = 16'h0004; qy = 16'h0005; qz = 16'h0006;
    rx = 16'h0007; ry = 16'h0008; rz = 16'h0009;
    cr = 8'hAA; cg = 8'hBB; cb = 8'hCC;
  endtask

  task automatic load_random_tri();
    px = 16'($urandom); py = 16'($urandom); pz = 16'($urandom);
    qx = 16'($urandom); qy = 16'($urandom); qz = 16'($urandom);
    rx = 16'($urandom); ry = 16'($urandom); rz = 16'($urandom);
    cr = 8'($urandom); cg = 8'($urandom); cb = 8'($urandom);
  endtask

  // Offer the loaded triangle, wait for the accept, then scramble the inputs
  task automatic apply_stimulus(input logic last);
    int k;
    src_last  = last;
    src_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!obs_read && k < 20);
    check_output("accept_seen", 32'(obs_read), 32'd1);
    @(posedge clk);
    #1;
    src_valid = 1'b0;
    load_random_tri();
    @(negedge clk);
    check_output("hdr_valid", 32'(obs_valid), 32'd1);
    check_output("hdr_word", obs_word, 32'h0000_0000);
    check_output("hdr_busy", 32'(obs_busy), 32'd1);
  endtask

  task automatic ack_cycles(input int cnt);
    @(posedge clk);
    #1;
    src_ack = 1'b1;
    repeat (cnt) @(posedge clk);
    #1;
    src_ack = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (obs_busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_output("idle_reached", 32'(obs_busy), 32'd0);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    check_output("idle_valid", 32'(obs_valid), 32'd0);
  endtask

  initial begin
    n_rst = 1'b0; sel = 1'b0;
    src_valid = 1'b0; src_last = 1'b0; src_ack = 1'b0;
    load_plan_tri();

    // Reset state
    repeat (2) @(negedge clk);
    check_output("rst_valid_a", 32'(ifa.word_valid), 32'd0);
    check_output("rst_word_a", ifa.word_out, 32'd0);
    check_output("rst_read_a", 32'(ifa.texel_read), 32'd0);
    check_output("rst_busy_a", 32'(busy_a), 32'd0);
    check_output("rst_cnt_a", 32'(cnt_a), 32'd0);
    check_output("rst_busy_b", 32'(busy_b), 32'd0);
    check_output("rst_cnt_b", 32'(cnt_b), 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    $display("[TB] reset released");

    // Single triangle, ack held high
    @(posedge clk);
    #1;
    src_ack = 1'b1;
    load_plan_tri();
    apply_stimulus(1'b0);
    wait_idle();
    check_output("single_cnt", 32'(cnt_a), 32'd1);

    // Last flag with trailer enabled
    @(posedge clk);
    #1;
    load_plan_tri();
    apply_stimulus(1'b1);
    wait_idle();
    check_output("last_cnt", 32'(cnt_a), 32'd2);

    // Backpressure during W2
    @(posedge clk);
    #1;
    src_ack = 1'b0;
    load_plan_tri();
    apply_stimulus(1'b0);
    ack_cycles(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp_hold_word", obs_word, 32'h0004_0003);
      check_output("bp_hold_valid", 32'(obs_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    src_ack = 1'b1;
    wait_idle();
    check_output("bp_cnt", 32'(cnt_a), 32'd3);

    // Source always valid across two triangles
    @(posedge clk);
    #1;
    load_plan_tri();
    src_last = 1'b0;
    src_valid = 1'b1;
    cyc = 0; reads = 0; first_rd = 0; second_rd = 0; changed = 1'b0;
    while (reads < 2 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (obs_read) begin
        reads++;
        if (reads == 1) first_rd = cyc;
        else second_rd = cyc;
      end
      if (reads == 1 && !changed) begin
        @(posedge clk);
        #1;
        load_random_tri();
        changed = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    src_valid = 1'b0;
    wait_idle();
    check_output("b2b_reads", 32'(reads), 32'd2);
    check_output("b2b_gap", 32'(second_rd - first_rd), 32'd8);
    check_output("b2b_cnt", 32'(cnt_a), 32'd5);

    // Reset in the middle of W3
    @(posedge clk);
    #1;
    src_ack = 1'b0;
    load_plan_tri();
    apply_stimulus(1'b0);
    ack_cycles(3);
    @(negedge clk);
    check_output("w3_word", obs_word, 32'h0006_0005);
    #2;
    n_rst = 1'b0;
    exp_q.delete();
    #1;
    check_output("midrst_valid", 32'(ifa.word_valid), 32'd0);
    check_output("midrst_busy", 32'(busy_a), 32'd0);
    check_output("midrst_cnt", 32'(cnt_a), 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    src_ack = 1'b1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (obs_valid) n++;
    end
    check_output("midrst_no_words", 32'(n), 32'd0);
    check_output("midrst_cnt_after", 32'(cnt_a), 32'd0);

    // Trailer disabled, 2-bit counter wrap on instance B
    @(posedge clk);
    #1;
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      load_random_tri();
      apply_stimulus(1'b1);
      wait_idle();
      check_output("wrap_cnt", 32'(cnt_b), 32'((i + 1) % 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
